// File: rtl/mem_datos_param.sv
// Parametrised data memory for the MEM stage: valid/ready request, pulsed response,
// byte/halfword/word little-endian access with programmable wait states and error reporting.
module mem_datos_param #(
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = 4;

    // state | meaning
    // IDLE  | ready for a request (req_ready high once the response pulse is over)
    // WAIT  | counting down programmed wait states
    // RESP  | response registered on the edge leaving this state
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [31:0]     mem [DEPTH];

    logic            lat_we;
    logic            lat_signed;
    logic            lat_err;
    logic [1:0]      lat_size;
    logic [1:0]      lat_lane;
    logic [AW-1:0]   lat_idx;

    logic            accept;
    logic            req_err;
    logic            addr_high;
    logic [3:0]      wr_mask;
    logic [31:0]     wr_data;
    logic            wr_en;
    logic [31:0]     rd_word;
    logic [7:0]      rd_byte;
    logic [15:0]     rd_half;
    logic [31:0]     load_val;

    assign accept    = req_valid && req_ready;
    assign addr_high = (req_addr >> (AW + 2)) != 32'd0;

    always_comb begin
        req_err = addr_high;
        case (req_size)
            2'b00:   req_err = addr_high;
            2'b01:   req_err = addr_high || req_addr[0];
            2'b10:   req_err = addr_high || (req_addr[1:0] != 2'b00);
            default: req_err = 1'b1;
        endcase
    end

    always_comb begin
        wr_mask = 4'b1111;
        wr_data = req_wdata;
        case (req_size)
            2'b00: begin
                wr_mask = 4'b0001 << req_addr[1:0];
                wr_data = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                wr_mask = req_addr[1] ? 4'b1100 : 4'b0011;
                wr_data = {2{req_wdata[15:0]}};
            end
            default: begin
                wr_mask = 4'b1111;
                wr_data = req_wdata;
            end
        endcase
    end

    // rst_n gates the write so a request coinciding with reset is never committed
    assign wr_en = accept && rst_n && req_we && !req_err;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_mask[b]) mem[req_addr[AW+1:2]][8*b +: 8] <= wr_data[8*b +: 8];
            end
        end
    end

    always_comb begin
        rd_word  = mem[lat_idx];
        rd_byte  = rd_word[8*lat_lane +: 8];
        rd_half  = lat_lane[1] ? rd_word[31:16] : rd_word[15:0];
        load_val = rd_word;
        case (lat_size)
            2'b00:   load_val = {{24{lat_signed & rd_byte[7]}}, rd_byte};
            2'b01:   load_val = {{16{lat_signed & rd_half[15]}}, rd_half};
            default: load_val = rd_word;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            req_ready  <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= '0;
            rsp_err    <= 1'b0;
            lat_we     <= 1'b0;
            lat_signed <= 1'b0;
            lat_err    <= 1'b0;
            lat_size   <= 2'b00;
            lat_lane   <= 2'b00;
            lat_idx    <= '0;
        end else begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            req_ready <= 1'b0;
            case (state)
                IDLE: begin
                    req_ready <= !accept;
                    if (accept) begin
                        lat_we     <= req_we;
                        lat_signed <= req_signed;
                        lat_err    <= req_err;
                        lat_size   <= req_size;
                        lat_lane   <= req_addr[1:0];
                        lat_idx    <= req_addr[AW+1:2];
                        if (WAIT_STATES > 0) begin
                            state <= WAIT;
                            cnt   <= CW'(WAIT_STATES - 1);
                        end else begin
                            state <= RESP;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == '0) state <= RESP;
                    else           cnt   <= cnt - 1'b1;
                end
                RESP: begin
                    state     <= IDLE;
                    rsp_valid <= 1'b1;
                    rsp_err   <= lat_err;
                    rsp_rdata <= (lat_we || lat_err) ? 32'd0 : load_val;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_datos_param.sv
// Randomised and directed bench for mem_datos_param: one instance without wait states,
// one with three, both checked against a byte-array reference model.
module tb_mem_datos_param;
    localparam int DEPTH = 64;
    localparam int WS0   = 0;
    localparam int WS1   = 3;

    logic        clk;
    logic        rst_n;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  valid;
    logic [1:0]  ready;
    logic [1:0]  rv;
    logic [1:0]  rerr;
    logic [31:0] rdata [2];

    int checks;
    int failures;

    logic [7:0] mdl [2][DEPTH*4];

    mem_datos_param #(.DEPTH(DEPTH), .WAIT_STATES(WS0)) dut0 (
        .clk(clk), .rst_n(rst_n), .req_valid(valid[0]), .req_ready(ready[0]),
        .req_we(req_we), .req_size(req_size), .req_signed(req_signed),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rv[0]), .rsp_rdata(rdata[0]), .rsp_err(rerr[0])
    );

    mem_datos_param #(.DEPTH(DEPTH), .WAIT_STATES(WS1)) dut1 (
        .clk(clk), .rst_n(rst_n), .req_valid(valid[1]), .req_ready(ready[1]),
        .req_we(req_we), .req_size(req_size), .req_signed(req_signed),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rv[1]), .rsp_rdata(rdata[1]), .rsp_err(rerr[1])
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: memory as a flat little-endian byte array
    function automatic void model(input int which, input bit we, input logic [1:0] size,
                                  input bit sgn, input logic [31:0] addr, input logic [31:0] wdata,
                                  output logic [31:0] rd, output bit err);
        int n;
        logic [31:0] v;
        n   = 1 << size;
        err = (size == 2'd3) || ((addr % n) != 0) || (addr >= DEPTH*4);
        rd  = 32'd0;
        if (err) return;
        if (we) begin
            for (int i = 0; i < n; i++) mdl[which][int'(addr) + i] = wdata[8*i +: 8];
        end else begin
            v = 32'd0;
            for (int i = 0; i < n; i++) v = v | (32'(mdl[which][int'(addr) + i]) << (8*i));
            if (sgn && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8*n)) - 32'd1);
            rd = v;
        end
    endfunction

    task automatic txn(input int which, input bit we, input logic [1:0] size, input bit sgn,
                       input logic [31:0] addr, input logic [31:0] wdata, output logic [31:0] got);
        logic [31:0] exp_rd;
        bit          exp_err;
        int          ws;
        int          waited;
        bit          seen;
        ws  = (which == 0) ? WS0 : WS1;
        got = 32'hx;
        waited = 0;
        @(negedge clk);
        while (!ready[which] && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!ready[which]) begin
            chk("ready_timeout", 32'(ready[which]), 32'd1);
            return;
        end
        req_we = we; req_size = size; req_signed = sgn; req_addr = addr; req_wdata = wdata;
        valid[which] = 1'b1;
        @(posedge clk);
        #1;
        valid[which] = 1'b0;
        model(which, we, size, sgn, addr, wdata, exp_rd, exp_err);
        chk("busy_after_accept", {30'd0, ready[which], rv[which]}, 32'd0);
        seen = 1'b0;
        for (int k = 1; k <= 20 && !seen; k++) begin
            @(posedge clk);
            #1;
            if (rv[which]) begin
                seen = 1'b1;
                got  = rdata[which];
                chk("latency", 32'(k), 32'(ws + 1));
                chk("ready_in_rsp", 32'(ready[which]), 32'd0);
                chk("rdata", rdata[which], exp_rd);
                chk("err", 32'(rerr[which]), 32'(exp_err));
            end else begin
                chk("ready_while_busy", 32'(ready[which]), 32'd0);
                chk("idle_outputs", rdata[which] | 32'(rerr[which]), 32'd0);
            end
        end
        if (!seen) begin
            chk("rsp_timeout", 32'd0, 32'd1);
            return;
        end
        @(posedge clk);
        #1;
        chk("after_rsp", {30'd0, ready[which], rv[which]}, 32'd2);
    endtask

    initial begin
        logic [31:0] r;
        logic [31:0] a;
        logic [1:0]  sz;
        int          w;
        clk = 1'b0; rst_n = 1'b0; valid = 2'b00;
        req_we = 1'b0; req_size = 2'b00; req_signed = 1'b0; req_addr = '0; req_wdata = '0;
        checks = 0; failures = 0;
        for (int i = 0; i < DEPTH*4; i++) begin
            mdl[0][i] = 8'h00;
            mdl[1][i] = 8'h00;
        end

        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {28'd0, ready, rv}, 32'd0);
        chk("reset_rdata", rdata[0] | rdata[1], 32'd0);
        chk("reset_err", 32'(rerr), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("ready_after_release", 32'(ready), 32'd3);

        for (int d = 0; d < 2; d++)
            for (int i = 0; i < DEPTH; i++) txn(d, 1'b1, 2'b10, 1'b0, 32'(4*i), 32'd0, r);

        txn(0, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, r);
        txn(0, 1'b0, 2'b10, 1'b0, 32'h10, 32'd0, r);
        chk("word_rd", r, 32'hDEADBEEF);

        txn(0, 1'b1, 2'b10, 1'b0, 32'h20, 32'h11223344, r);
        txn(0, 1'b1, 2'b00, 1'b0, 32'h23, 32'h00000080, r);
        txn(0, 1'b0, 2'b10, 1'b0, 32'h20, 32'd0, r);
        chk("byte_merge", r, 32'h80223344);
        txn(0, 1'b0, 2'b00, 1'b1, 32'h23, 32'd0, r);
        chk("byte_signed", r, 32'hFFFFFF80);
        txn(0, 1'b0, 2'b00, 1'b0, 32'h23, 32'd0, r);
        chk("byte_unsigned", r, 32'h00000080);

        txn(0, 1'b1, 2'b01, 1'b0, 32'h42, 32'h0000A5F0, r);
        txn(0, 1'b0, 2'b10, 1'b0, 32'h40, 32'd0, r);
        chk("half_merge", r, 32'hA5F00000);
        txn(0, 1'b0, 2'b01, 1'b1, 32'h42, 32'd0, r);
        chk("half_signed", r, 32'hFFFFA5F0);

        txn(0, 1'b0, 2'b10, 1'b0, 32'h06, 32'd0, r);
        txn(0, 1'b0, 2'b01, 1'b0, 32'h05, 32'd0, r);
        txn(0, 1'b0, 2'b11, 1'b0, 32'h08, 32'd0, r);
        txn(0, 1'b0, 2'b10, 1'b0, 32'(DEPTH*4), 32'd0, r);
        txn(0, 1'b0, 2'b10, 1'b0, 32'h8000_0010, 32'd0, r);
        txn(0, 1'b1, 2'b10, 1'b0, 32'h06, 32'h55555555, r);
        txn(0, 1'b1, 2'b01, 1'b0, 32'h05, 32'h66666666, r);
        txn(0, 1'b1, 2'b11, 1'b0, 32'h08, 32'h77777777, r);
        txn(0, 1'b1, 2'b10, 1'b0, 32'(DEPTH*4), 32'h88888888, r);
        txn(0, 1'b0, 2'b10, 1'b0, 32'h04, 32'd0, r);
        chk("err_store_w1", r, 32'd0);
        txn(0, 1'b0, 2'b10, 1'b0, 32'h08, 32'd0, r);
        chk("err_store_w2", r, 32'd0);
        txn(0, 1'b0, 2'b10, 1'b0, 32'h00, 32'd0, r);
        chk("no_wrap", r, 32'd0);
        txn(0, 1'b1, 2'b10, 1'b0, 32'(DEPTH*4-4), 32'hA1B2C3D4, r);
        txn(0, 1'b0, 2'b10, 1'b0, 32'(DEPTH*4-4), 32'd0, r);
        chk("last_word", r, 32'hA1B2C3D4);

        txn(1, 1'b1, 2'b10, 1'b0, 32'h30, 32'hCAFEF00D, r);
        txn(1, 1'b0, 2'b01, 1'b1, 32'h32, 32'd0, r);
        chk("ws3_half", r, 32'hFFFFCAFE);

        // Reset during WAIT of a load on dut1, with a store offered to dut0 on the reset edge
        @(negedge clk);
        req_we = 1'b0; req_size = 2'b10; req_signed = 1'b0; req_addr = 32'h30; req_wdata = 32'd0;
        valid[1] = 1'b1;
        @(posedge clk);
        #1;
        valid[1] = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        req_we = 1'b1; req_addr = 32'h30; req_wdata = 32'h12345678;
        valid = 2'b11;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            chk("rst_hold_ctrl", {28'd0, ready, rv}, 32'd0);
            chk("rst_hold_data", rdata[0] | rdata[1] | 32'(rerr), 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        valid = 2'b00;
        @(posedge clk);
        #1;
        chk("ready_post_rst", {28'd0, ready, rv}, 32'd12);
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            chk("no_stale_rsp", 32'(rv), 32'd0);
        end
        txn(1, 1'b0, 2'b10, 1'b0, 32'h30, 32'd0, r);
        chk("kept_after_rst", r, 32'hCAFEF00D);
        txn(0, 1'b0, 2'b10, 1'b0, 32'h30, 32'd0, r);
        chk("rst_store_blocked", r, 32'd0);

        for (int n = 0; n < 200; n++) begin
            w  = $urandom_range(0, 1);
            sz = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            case ($urandom_range(0, 19))
                0:       a = $urandom;
                1:       a = 32'(DEPTH*4 + $urandom_range(0, 15));
                default: a = 32'($urandom_range(0, DEPTH*4 - 1));
            endcase
            if ($urandom_range(0, 3) != 0 && sz != 2'b11) a = a & ~((32'd1 << sz) - 32'd1);
            txn(w, 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom, r);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule
